// File: rtl/mesh_router_rr.sv
// 5-port single-flit mesh router: per-input FIFOs, XY routing from runtime
// coordinates, per-output round-robin arbitration and illegal-destination drop.
module mesh_router_rr #(
  parameter int DW     = 64,
  parameter int CW     = 4,
  parameter int DEPTH  = 4,
  parameter int MESH_X = 4,
  parameter int MESH_Y = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CW-1:0]   pos_x,
  input  logic [CW-1:0]   pos_y,
  input  logic [4:0]      si,
  input  logic [5*DW-1:0] di,
  output logic [4:0]      ri,
  output logic [4:0]      so,
  // 'do' is a reserved word, so the output flit bus carries the _o suffix
  output logic [5*DW-1:0] do_o,
  input  logic [4:0]      ro,
  output logic            polarity_out,
  output logic            err
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [NW-1:0] FULL = NW'(DEPTH);
  localparam logic [CW:0]   MX   = (CW+1)'(MESH_X);
  localparam logic [CW:0]   MY   = (CW+1)'(MESH_Y);

  typedef enum logic [2:0] {
    P_PE = 3'd0, P_N = 3'd1, P_S = 3'd2, P_E = 3'd3, P_W = 3'd4
  } port_e;

  logic [DW-1:0] mem_q [5][DEPTH];
  logic [AW-1:0] wr_q  [5];
  logic [AW-1:0] rd_q  [5];
  logic [NW-1:0] cnt_q [5];
  logic [2:0]    ptr_q [5];
  logic [DW-1:0] dat_q [5];
  logic [4:0]    so_q;
  logic          pol_q;
  logic          err_q;

  logic [DW-1:0] head  [5];
  logic [CW-1:0] dx    [5];
  logic [CW-1:0] dy    [5];
  port_e         route [5];
  logic [2:0]    gnt   [5];
  logic [4:0]    hv, bad, push, pop, ld;

  always_comb begin
    for (int unsigned i = 0; i < 5; i++) begin
      head[i] = mem_q[i][rd_q[i]];
      hv[i]   = cnt_q[i] != '0;
      dx[i]   = head[i][DW-9 -: CW];
      dy[i]   = head[i][DW-9-CW -: CW];
      bad[i]  = hv[i] && (({1'b0, dx[i]} >= MX) || ({1'b0, dy[i]} >= MY));
      if (dx[i] > pos_x)      route[i] = P_E;
      else if (dx[i] < pos_x) route[i] = P_W;
      else if (dy[i] > pos_y) route[i] = P_S;
      else if (dy[i] < pos_y) route[i] = P_N;
      else                    route[i] = P_PE;
      ri[i]   = cnt_q[i] != FULL;
      push[i] = si[i] && ri[i];
    end
  end

  // Each head targets exactly one output, so an input can win at most one grant.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    sum = '0;
    idx = '0;
    ld  = '0;
    pop = '0;
    for (int unsigned o = 0; o < 5; o++) begin
      gnt[o] = '0;
      if (!so_q[o] || ro[o]) begin
        for (int unsigned k = 0; k < 5; k++) begin
          sum = {1'b0, ptr_q[o]} + 4'(k);
          idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
          if (!ld[o] && hv[idx] && !bad[idx] && route[idx] == port_e'(3'(o))) begin
            ld[o]  = 1'b1;
            gnt[o] = idx;
          end
        end
      end
    end
    pop = bad;
    for (int unsigned o = 0; o < 5; o++)
      if (ld[o]) pop[gnt[o]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 5; i++)
      if (push[i]) mem_q[i][wr_q[i]] <= di[i*DW +: DW];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 5; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
        ptr_q[i] <= '0;
        dat_q[i] <= '0;
      end
      so_q  <= '0;
      pol_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pol_q <= ~pol_q;
      if (|bad) err_q <= 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
        if (push[i]) wr_q[i] <= wr_q[i] + AW'(1);
        if (pop[i])  rd_q[i] <= rd_q[i] + AW'(1);
        if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + NW'(1);
        else if (!push[i] && pop[i]) cnt_q[i] <= cnt_q[i] - NW'(1);
      end
      for (int unsigned o = 0; o < 5; o++) begin
        if (ld[o]) begin
          so_q[o]  <= 1'b1;
          dat_q[o] <= head[gnt[o]];
          ptr_q[o] <= (gnt[o] == 3'd4) ? 3'd0 : gnt[o] + 3'd1;
        end else if (ro[o]) begin
          so_q[o] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    do_o = '0;
    for (int unsigned o = 0; o < 5; o++) do_o[o*DW +: DW] = dat_q[o];
  end

  assign so           = so_q;
  assign polarity_out = pol_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mesh_router_rr.sv
// Bench for mesh_router_rr: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mesh_router_rr;
  localparam int DW = 64;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [3:0]      pos_x = 4'd1;
  logic [3:0]      pos_y = 4'd1;
  logic [4:0]      si = '0;
  logic [5*DW-1:0] di = '0;
  logic [4:0]      ro = '0;
  logic [4:0]      ri, so;
  logic [5*DW-1:0] do_o;
  logic            polarity_out, err;

  always #5 clk = ~clk;

  mesh_router_rr #(.DW(DW), .CW(4), .DEPTH(DEPTH), .MESH_X(4), .MESH_Y(4)) dut (
    .clk(clk), .reset(reset), .pos_x(pos_x), .pos_y(pos_y),
    .si(si), .di(di), .ri(ri), .so(so), .do_o(do_o), .ro(ro),
    .polarity_out(polarity_out), .err(err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: flits as queues, outputs as a valid/data pair per port.
  logic [DW-1:0] mq [5][$];
  bit            mov [5];
  logic [DW-1:0] md [5];
  int            mptr [5];
  bit            merr, mpol;

  function automatic int dest_port(input logic [DW-1:0] f, input int px, input int py);
    int dx;
    int dy;
    dx = int'(f[55:52]);
    dy = int'(f[51:48]);
    if (dx >= 4 || dy >= 4) return -1;
    if (dx > px) return 3;
    if (dx < px) return 4;
    if (dy > py) return 2;
    if (dy < py) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    int tgt [5];
    bit rdy [5];
    int w;
    int ii;
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        mq[i].delete();
        mov[i] = 0;
        md[i] = '0;
        mptr[i] = 0;
      end
      merr = 0;
      mpol = 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        rdy[i] = mq[i].size() < DEPTH;
        tgt[i] = (mq[i].size() > 0) ? dest_port(mq[i][0], int'(pos_x), int'(pos_y)) : -2;
      end
      for (int i = 0; i < 5; i++)
        if (tgt[i] == -1) begin
          merr = 1;
          void'(mq[i].pop_front());
        end
      for (int o = 0; o < 5; o++) begin
        if (!mov[o] || ro[o]) begin
          w = -1;
          for (int k = 0; k < 5; k++) begin
            ii = (mptr[o] + k) % 5;
            if (w < 0 && tgt[ii] == o) w = ii;
          end
          if (w >= 0) begin
            md[o] = mq[w].pop_front();
            mov[o] = 1;
            mptr[o] = (w + 1) % 5;
          end else begin
            mov[o] = 0;
          end
        end
      end
      for (int i = 0; i < 5; i++)
        if (si[i] && rdy[i]) mq[i].push_back(di[i*DW +: DW]);
      mpol = !mpol;
    end
  end

  always @(negedge clk) begin
    logic [4:0] mri, mso;
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        mri[i] = mq[i].size() < DEPTH;
        mso[i] = mov[i];
      end
      chk("model_ri", ri, mri);
      chk("model_so", so, mso);
      for (int o = 0; o < 5; o++)
        if (mov[o]) chk($sformatf("model_do%0d", o), do_o[o*DW +: DW], md[o]);
      chk("model_err", err, merr);
      chk("model_pol", polarity_out, mpol);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send1(input int p, input logic [63:0] f);
    int n;
    n = 0;
    while (!ri[p] && n < 20) begin tick(); n++; end
    chk("send_ready", ri[p], 1'b1);
    si[p] = 1'b1;
    di[p*DW +: DW] = f;
    tick();
    si[p] = 1'b0;
  endtask

  task automatic route_test(input string nm, input int p, input logic [63:0] f, input int e);
    int n;
    logic [4:0] onehot;
    onehot = 5'(1 << e);
    send1(p, f);
    n = 0;
    while (!so[e] && n < 10) begin tick(); n++; end
    chk({nm, "_so"}, so, onehot);
    chk({nm, "_do"}, do_o[e*DW +: DW], f);
    tick();
  endtask

  function automatic logic [63:0] rflit();
    logic [63:0] f;
    f = {$urandom, $urandom};
    f[55:52] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
    f[51:48] = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
    return f;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    logic anyso;
    logic [63:0] fa, fb, fc, fd;

    // Reset and polarity
    ro = '1;
    repeat (3) tick();
    chk("rst_so", so, 5'b0);
    chk("rst_ri", ri, 5'b11111);
    chk("rst_err", err, 1'b0);
    chk("rst_pol", polarity_out, 1'b0);
    reset = 1'b1;
    chk("pol0", polarity_out, 1'b0);
    tick(); chk("pol1", polarity_out, 1'b1);
    tick(); chk("pol2", polarity_out, 1'b0);
    tick(); chk("pol3", polarity_out, 1'b1);

    // Local delivery: exact 2-edge latency, one-cycle pulse
    send1(0, 64'h0011_0000_0000_FA50);
    chk("local_early", so, 5'b0);
    tick();
    chk("local_so", so, 5'b00001);
    chk("local_do", do_o[0 +: DW], 64'h0011_0000_0000_FA50);
    tick();
    chk("local_gone", so, 5'b0);

    // XY routing from (1,1)
    route_test("w_to_e", 4, 64'h0031_0000_0000_0001, 3);
    route_test("n_to_s", 1, 64'h0013_0000_0000_0002, 2);
    route_test("e_to_n", 3, 64'h0010_0000_0000_0003, 1);
    route_test("s_to_w", 2, 64'h0002_0000_0000_0004, 4);

    // Contention on E: second pair arrives while W still waits
    fa = 64'h0031_0000_0000_00A0; fb = 64'h0031_0000_0000_00B0;
    fc = 64'h0031_0000_0000_00C0; fd = 64'h0031_0000_0000_00D0;
    si = 5'b10001; di[0 +: DW] = fa; di[4*DW +: DW] = fb;
    tick();
    di[0 +: DW] = fc; di[4*DW +: DW] = fd;
    tick();
    si = '0;
    chk("cont_1", do_o[3*DW +: DW], fa);
    tick(); chk("cont_2", do_o[3*DW +: DW], fb);
    tick(); chk("cont_3", do_o[3*DW +: DW], fc);
    tick(); chk("cont_4", do_o[3*DW +: DW], fd);
    chk("cont_so", so[3], 1'b1);
    tick(); chk("cont_end", so[3], 1'b0);

    // Backpressure W->E: DEPTH+1 flits absorbed
    ro[3] = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      si[4] = 1'b1;
      di[4*DW +: DW] = 64'h0031_0000_0000_0000 | 64'(acc + 1);
      if (ri[4]) acc++;
      tick();
    end
    si[4] = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_ri_low", ri[4], 1'b0);
    ro[3] = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      chk($sformatf("bp_so_%0d", j), so[3], 1'b1);
      chk($sformatf("bp_do_%0d", j), do_o[3*DW +: DW], 64'h0031_0000_0000_0000 | 64'(j));
      tick();
      if (j == 1) chk("bp_ri_rise", ri[4], 1'b1);
    end
    chk("bp_drained", so[3], 1'b0);

    // Illegal destination then a legal one
    send1(0, 64'h0040_0000_0000_0BAD);
    chk("ill_err_pre", err, 1'b0);
    tick();
    chk("ill_err", err, 1'b1);
    anyso = 1'b0;
    for (int c = 0; c < 5; c++) begin anyso |= |so; tick(); end
    chk("ill_no_so", anyso, 1'b0);
    chk("ill_sticky", err, 1'b1);
    route_test("after_ill", 0, 64'h0011_0000_0000_0C0D, 0);
    reset = 1'b0;
    tick(); tick();
    chk("rst_err_clear", err, 1'b0);

    // Randomized traffic at a new position
    pos_x = 4'($urandom_range(0, 3));
    pos_y = 4'($urandom_range(0, 3));
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      si = 5'($urandom);
      ro = 5'($urandom) | 5'($urandom);
      for (int i = 0; i < 5; i++) di[i*DW +: DW] = rflit();
      tick();
    end
    si = '0;
    ro = '1;
    repeat (20) tick();
    chk("final_so", so, 5'b0);
    chk("final_ri", ri, 5'b11111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
